// File: rtl/rx_fcs_checker.sv
// Ethernet RX FCS checker: holds back the trailing 4-byte FCS, strips it, recomputes CRC32 over the payload and
// flags the frame on its last payload beat. Define RX_FCS_STATS_EN to add saturating good/bad frame counters.
module rx_fcs_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int FCS_BYTES  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] s_rx_data,
  input  logic                  s_rx_valid,
  input  logic                  s_rx_last,
  input  logic                  s_rx_err,
  output logic [DATA_WIDTH-1:0] m_rx_data,
  output logic                  m_rx_valid,
  output logic                  m_rx_last,
  output logic                  m_rx_bad
`ifdef RX_FCS_STATS_EN
  ,
  output logic [31:0]           o_good_cnt,
  output logic [31:0]           o_bad_cnt
`endif
);

  localparam int              CNT_W     = 3;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FCS_BYTES);
  localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(FCS_BYTES - 1);
  localparam logic [31:0]     CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0]     CRC_POLY  = 32'h04C1_1DB7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  // MSB-first CRC step over a bit-reversed byte: data bit i is consumed at step i.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0};
      if (fb) begin
        c = c ^ CRC_POLY;
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t                  state_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [31:0]             crc_r;
  logic                    err_r;
  logic [DATA_WIDTH-1:0]   line_r [FCS_BYTES];

  logic [31:0]             crc_next_s;
  logic [31:0]             fcs_calc_s;
  logic [31:0]             fcs_rx_s;
  logic                    stream_s;
  logic                    frame_bad_s;

  // CRC including the byte being pushed out, and the received FCS assembled little-endian.
  always_comb begin
    crc_next_s  = crc32_byte(crc_r, line_r[FCS_BYTES-1]);
    fcs_calc_s  = ~bitrev32(crc_next_s);
    fcs_rx_s    = {s_rx_data, line_r[0], line_r[1], line_r[2]};
    stream_s    = (state_r == STREAM);
    frame_bad_s = (fcs_calc_s != fcs_rx_s) | err_r | s_rx_err;
  end

  // Delay line, frame FSM, CRC accumulation and registered output beat.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      crc_r      <= CRC_INIT;
      err_r      <= 1'b0;
      m_rx_data  <= '0;
      m_rx_valid <= 1'b0;
      m_rx_last  <= 1'b0;
      m_rx_bad   <= 1'b0;
      for (int i = 0; i < FCS_BYTES; i++) begin
        line_r[i] <= '0;
      end
`ifdef RX_FCS_STATS_EN
      o_good_cnt <= 32'd0;
      o_bad_cnt  <= 32'd0;
`endif
    end else begin
      m_rx_valid <= 1'b0;
      m_rx_last  <= 1'b0;
      m_rx_bad   <= 1'b0;
      if (s_rx_valid) begin
        line_r[0] <= s_rx_data;
        for (int i = 1; i < FCS_BYTES; i++) begin
          line_r[i] <= line_r[i-1];
        end
        if (stream_s) begin
          m_rx_data  <= line_r[FCS_BYTES-1];
          m_rx_valid <= 1'b1;
        end
        if (s_rx_last) begin
          // Runts (line never filled) emit nothing and only count as bad.
          m_rx_last <= stream_s;
          m_rx_bad  <= stream_s & frame_bad_s;
          state_r   <= IDLE;
          cnt_r     <= '0;
          crc_r     <= CRC_INIT;
          err_r     <= 1'b0;
`ifdef RX_FCS_STATS_EN
          if (stream_s && !frame_bad_s) begin
            o_good_cnt <= sat_inc(o_good_cnt);
          end else begin
            o_bad_cnt  <= sat_inc(o_bad_cnt);
          end
`endif
        end else begin
          err_r <= err_r | s_rx_err;
          if (stream_s) begin
            crc_r <= crc_next_s;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
          case (state_r)
            IDLE:    state_r <= FILL;
            FILL:    state_r <= (cnt_r == LAST_FILL) ? STREAM : FILL;
            STREAM:  state_r <= STREAM;
            default: state_r <= IDLE;
          endcase
        end
      end
    end
  end

  logic unused_s;
  assign unused_s = ^{FULL_CNT};

endmodule

// File: tb/tb_rx_fcs_checker.sv
// Table-driven bench for rx_fcs_checker: directed frames with hand-computed FCS, plus back-to-back,
// mid-frame reset and gapped random frames checked against a reflected-CRC32 reference model.
module tb_rx_fcs_checker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] s_rx_data;
  logic       s_rx_valid, s_rx_last, s_rx_err;
  logic [7:0] m_rx_data;
  logic       m_rx_valid, m_rx_last, m_rx_bad;
`ifdef RX_FCS_STATS_EN
  logic [31:0] o_good_cnt, o_bad_cnt;
`endif

  rx_fcs_checker dut (
    .clk(clk), .reset_n(reset_n),
    .s_rx_data(s_rx_data), .s_rx_valid(s_rx_valid), .s_rx_last(s_rx_last), .s_rx_err(s_rx_err),
    .m_rx_data(m_rx_data), .m_rx_valid(m_rx_valid), .m_rx_last(m_rx_last), .m_rx_bad(m_rx_bad)
`ifdef RX_FCS_STATS_EN
    , .o_good_cnt(o_good_cnt), .o_bad_cnt(o_bad_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       bad;
    int         cyc;
  } beat_t;

  typedef struct {
    string        name;
    logic [103:0] bytes;   // first byte in the most significant used position
    int           len;
    int           err_idx;
    int           gap_mode;
    int           exp_payload;
    logic         exp_bad;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         stray = 0;
  int         last_cnt = 0;
  beat_t      out_q[$];
  beat_t      exp_q[$];
  int         in_cyc[$];
  logic [7:0] tx_q[$];
  vec_t       vecs[11];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_rx_valid) out_q.push_back('{m_rx_data, m_rx_last, m_rx_bad, cyc});
    else if (m_rx_last || m_rx_bad) stray++;
    if (m_rx_last) last_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reflected CRC32 (poly EDB88320) over tx_q[0..n-1].
  function automatic logic [31:0] model_fcs(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, tx_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic load_vec(input logic [103:0] bytes, input int len);
    tx_q.delete();
    for (int i = 0; i < len; i++) tx_q.push_back(bytes[8*(len-1-i) +: 8]);
  endtask

  task automatic expect_frame(input logic bad);
    int n;
    n = tx_q.size() - 4;
    for (int i = 0; i < n; i++) exp_q.push_back('{tx_q[i], (i == n-1), (i == n-1) ? bad : 1'b0, 0});
  endtask

  task automatic drive_q(input int err_idx, input int gap_mode, input bit idle_after);
    int g;
    for (int i = 0; i < tx_q.size(); i++) begin
      s_rx_data  = tx_q[i];
      s_rx_valid = 1'b1;
      s_rx_last  = (i == tx_q.size() - 1);
      s_rx_err   = (i == err_idx);
      in_cyc.push_back(cyc + 1);
      @(posedge clk); #1;
      if (i != tx_q.size() - 1) begin
        g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        for (int j = 0; j < g; j++) begin
          s_rx_valid = 1'b0; s_rx_last = 1'b0; s_rx_err = 1'b1; s_rx_data = 8'hEE;
          @(posedge clk); #1;
        end
      end
    end
    if (idle_after) begin
      s_rx_valid = 1'b0; s_rx_last = 1'b0; s_rx_err = 1'b0;
    end
  endtask

  task automatic compare_outputs(input string name, input bit check_lat);
    int n;
    repeat (4) @(posedge clk);
    #1;
    chk({name, " count"}, out_q.size(), exp_q.size());
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s data[%0d]", name, k), out_q[k].data, exp_q[k].data);
      chk($sformatf("%s last[%0d]", name, k), out_q[k].last, exp_q[k].last);
      chk($sformatf("%s bad[%0d]", name, k), out_q[k].bad, exp_q[k].bad);
      if (check_lat && (k + 4 < in_cyc.size()))
        chk($sformatf("%s latency[%0d]", name, k), out_q[k].cyc, in_cyc[k+4]);
    end
    chk({name, " stray"}, stray, 0);
    out_q.delete(); exp_q.delete(); in_cyc.delete(); stray = 0;
  endtask

  localparam logic [103:0] CASE1 = 104'h31_32_33_34_35_36_37_38_39_26_39_F4_CB;

  initial begin
    int   l0;
`ifdef RX_FCS_STATS_EN
    logic [31:0] bad0;
`endif
    vecs[0]  = '{"good_123456789", CASE1, 13, -1, 0, 9, 1'b0};
    vecs[1]  = '{"fcs_corrupt", 104'h31_32_33_34_35_36_37_38_39_26_39_F5_CB, 13, -1, 0, 9, 1'b1};
    vecs[2]  = '{"phy_err_mid", CASE1, 13, 4, 0, 9, 1'b1};
    vecs[3]  = '{"runt3", 104'hAA_BB_CC, 3, -1, 0, 0, 1'b0};
    vecs[4]  = '{"gaps_err_ignored", CASE1, 13, -1, 1, 9, 1'b0};
    vecs[5]  = '{"min_frame_00", 104'h00_8D_EF_02_D2, 5, -1, 0, 1, 1'b0};
    vecs[6]  = '{"min_frame_a", 104'h61_43_BE_B7_E8, 5, -1, 0, 1, 1'b0};
    vecs[7]  = '{"runt4", 104'hDE_AD_BE_EF, 4, -1, 0, 0, 1'b0};
    vecs[8]  = '{"runt1", 104'h55, 1, -1, 0, 0, 1'b0};
    vecs[9]  = '{"phy_err_last", CASE1, 13, 12, 0, 9, 1'b1};
    vecs[10] = '{"random_gaps", CASE1, 13, -1, 2, 9, 1'b0};

    reset_n = 1'b0; s_rx_data = 8'h00; s_rx_valid = 1'b0; s_rx_last = 1'b0; s_rx_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("reset m_rx_valid", m_rx_valid, 1'b0);
    chk("reset m_rx_last", m_rx_last, 1'b0);
    chk("reset m_rx_bad", m_rx_bad, 1'b0);
    chk("reset m_rx_data", m_rx_data, 8'h00);
`ifdef RX_FCS_STATS_EN
    chk("reset good_cnt", o_good_cnt, 32'd0);
    chk("reset bad_cnt", o_bad_cnt, 32'd0);
`endif
    @(posedge clk); #1;

    for (int v = 0; v < 11; v++) begin
`ifdef RX_FCS_STATS_EN
      bad0 = o_bad_cnt;
`endif
      load_vec(vecs[v].bytes, vecs[v].len);
      for (int i = 0; i < vecs[v].exp_payload; i++)
        exp_q.push_back('{tx_q[i], (i == vecs[v].exp_payload-1),
                          (i == vecs[v].exp_payload-1) ? vecs[v].exp_bad : 1'b0, 0});
      drive_q(vecs[v].err_idx, vecs[v].gap_mode, 1'b1);
      compare_outputs(vecs[v].name, 1'b1);
`ifdef RX_FCS_STATS_EN
      if (vecs[v].exp_payload == 0) chk({vecs[v].name, " bad_cnt"}, o_bad_cnt, bad0 + 32'd1);
`endif
    end

    // Back-to-back: second frame's first byte on the clock right after the first frame's last byte.
    l0 = last_cnt;
    load_vec(CASE1, 13);
    expect_frame(1'b0);
    drive_q(-1, 0, 1'b0);
    expect_frame(1'b0);
    drive_q(-1, 0, 1'b1);
    compare_outputs("back_to_back", 1'b0);
    chk("back_to_back last pulses", last_cnt - l0, 2);

    // Reset one clock after byte 0x35, then a clean frame.
    l0 = last_cnt;
    load_vec(104'h31_32_33_34_35, 5);
    for (int i = 0; i < 5; i++) begin
      s_rx_data = tx_q[i]; s_rx_valid = 1'b1; s_rx_last = 1'b0; s_rx_err = 1'b0;
      @(posedge clk); #1;
    end
    s_rx_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort no last", last_cnt - l0, 0);
    chk("abort stray", stray, 0);
    out_q.delete(); in_cyc.delete(); stray = 0;
    load_vec(CASE1, 13);
    expect_frame(1'b0);
    drive_q(-1, 0, 1'b1);
    compare_outputs("after_abort", 1'b1);

    // Random payload frames with random gaps; one with a PHY error, one with a corrupted payload byte.
    for (int f = 0; f < 5; f++) begin
      logic [31:0] fcs;
      int          n;
      int          eidx;
      n = $urandom_range(60, 120);
      tx_q.delete();
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
      fcs = model_fcs(n);
      tx_q.push_back(fcs[7:0]); tx_q.push_back(fcs[15:8]);
      tx_q.push_back(fcs[23:16]); tx_q.push_back(fcs[31:24]);
      if (f == 3) tx_q[10] = tx_q[10] ^ 8'h01;
      eidx = (f == 2) ? int'($urandom_range(0, n)) : -1;
      expect_frame((f == 2) || (f == 3));
      drive_q(eidx, 2, 1'b1);
      compare_outputs($sformatf("rand%0d", f), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
